// File: rtl/jtframe_pocket_pkg.sv
// +---------------------------------------------------------------------------+
// | jtframe_pocket_pkg: shared constants for the Pocket bridge command block. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package jtframe_pocket_pkg;

  localparam logic [11:0] WIN_TAG    = 12'hF80;

  localparam logic [19:0] OFS_CMD    = 20'h00000;
  localparam logic [19:0] OFS_PARAM0 = 20'h00004;
  localparam logic [19:0] OFS_PARAM1 = 20'h00008;
  localparam logic [19:0] OFS_STAT   = 20'h00010;
  localparam logic [19:0] OFS_LOG    = 20'h00020;
  localparam logic [19:0] OFS_DIP_LO = 20'h00100;
  localparam logic [19:0] OFS_DIP_HI = 20'h00104;

  localparam logic [15:0] CMD_TAG        = 16'h434D;
  localparam logic [15:0] OP_NOP         = 16'h0000;
  localparam logic [15:0] OP_RESET_ENTER = 16'h0010;
  localparam logic [15:0] OP_RESET_EXIT  = 16'h0011;
  localparam logic [15:0] OP_SLOT_LOAD   = 16'h0080;
  localparam logic [15:0] OP_DIP_COMMIT  = 16'h0090;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_RST_HOLD  = 3'd2;
  localparam state_t ST_LOAD      = 3'd3;
  localparam state_t ST_LOAD_WAIT = 3'd4;
  localparam state_t ST_DONE      = 3'd5;
  localparam state_t ST_ERR       = 3'd6;

  localparam int STAT_BUSY = 31;
  localparam int STAT_DONE = 30;
  localparam int STAT_ERR  = 29;
  localparam int STAT_OVF  = 28;

  function automatic logic [31:0] pack_stat(input logic busy, input logic done,
                                            input logic err, input logic ovf,
                                            input logic [15:0] opcode);
    logic [31:0] s;
    s            = {16'd0, opcode};
    s[STAT_BUSY] = busy;
    s[STAT_DONE] = done;
    s[STAT_ERR]  = err;
    s[STAT_OVF]  = ovf;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_pocket_cmdlog.sv
// +---------------------------------------------------------------------------+
// | jtframe_pocket_cmdlog: 8-entry ring of {err, done, opcode} results.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module jtframe_pocket_cmdlog (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        we,
  input  logic [17:0] wdata,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata
);

  logic [17:0] ent_q [8];
  logic [17:0] ent_d [8];
  logic [2:0]  ptr_q, ptr_d;

  always_comb begin
    ent_d = ent_q;
    ptr_d = ptr_q;
    if (we) begin
      ent_d[ptr_q] = wdata;
      ptr_d        = ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ent_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      ent_q <= ent_d;
      ptr_q <= ptr_d;
    end
  end

  assign rdata = {14'd0, ent_q[raddr]};

endmodule

`default_nettype wire

// File: rtl/jtframe_pocket_cmd.sv
// +---------------------------------------------------------------------------+
// | jtframe_pocket_cmd: APF bridge command sequencer (reset/load/DIP commit). |
// | Optional: JTFRAME_POCKET_CMDLOG_EN adds a readable 8-entry command log.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module jtframe_pocket_cmd
  import jtframe_pocket_pkg::*;
#(
  parameter logic [23:0] TIMEOUT     = 24'd12_000_000,
  parameter logic [63:0] DIP_DEFAULT = 64'd0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  output logic [31:0] bridge_rd_data,
  input  logic        dwnld_busy,
  output logic [63:0] status,
  output logic        rst_req,
  output logic        downloading,
  output logic        load_start,
  output logic [15:0] slot_id,
  output logic [31:0] slot_size
);

  state_t      state_q, state_d;
  logic [15:0] opcode_q, opcode_d;
  logic        done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic        rst_req_q, rst_req_d, downloading_q, downloading_d;
  logic        load_start_q, load_start_d;
  logic [15:0] slot_id_q, slot_id_d;
  logic [31:0] slot_size_q, slot_size_d;
  logic [31:0] param0_q, param0_d, param1_q, param1_d;
  logic [63:0] dip_q, dip_d, status_q, status_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        log_we_q, log_we_d;

  logic        w_hit, w_cmd_wr, w_tag_ok, w_busy, w_timeout;
  logic [19:0] w_ofs;
  logic [15:0] w_op;
  logic [31:0] w_rd_val, w_log_rdata;

  assign w_hit     = bridge_addr[31:20] == WIN_TAG;
  assign w_ofs     = bridge_addr[19:0];
  assign w_cmd_wr  = bridge_wr && w_hit && (w_ofs == OFS_CMD);
  assign w_tag_ok  = bridge_wr_data[31:16] == CMD_TAG;
  assign w_op      = bridge_wr_data[15:0];
  assign w_busy    = (state_q == ST_DECODE) || (state_q == ST_LOAD) || (state_q == ST_LOAD_WAIT);
  assign w_timeout = cnt_q == (TIMEOUT - 24'd1);

`ifdef JTFRAME_POCKET_CMDLOG_EN
  jtframe_pocket_cmdlog u_cmdlog (
    .clk_sys (clk_sys),
    .rst     (rst),
    .we      (log_we_q),
    .wdata   ({err_q, done_q, opcode_q}),
    .raddr   (w_ofs[4:2]),
    .rdata   (w_log_rdata)
  );
`else
  assign w_log_rdata = 32'd0;
`endif

  // Read mux works on registered state only, so a same-cycle write is not visible.
  always_comb begin
    w_rd_val = 32'd0;
    if (w_hit) begin
      case (w_ofs)
        OFS_PARAM0: w_rd_val = param0_q;
        OFS_PARAM1: w_rd_val = param1_q;
        OFS_STAT:   w_rd_val = pack_stat(w_busy, done_q, err_q, ovf_q, opcode_q);
        OFS_DIP_LO: w_rd_val = dip_q[31:0];
        OFS_DIP_HI: w_rd_val = dip_q[63:32];
        default: begin
          if (w_ofs[19:5] == OFS_LOG[19:5] && w_ofs[1:0] == 2'b00)
            w_rd_val = w_log_rdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    done_d        = done_q;
    err_d         = err_q;
    ovf_d         = ovf_q;
    rst_req_d     = rst_req_q;
    downloading_d = downloading_q;
    load_start_d  = 1'b0;
    slot_id_d     = slot_id_q;
    slot_size_d   = slot_size_q;
    param0_d      = param0_q;
    param1_d      = param1_q;
    dip_d         = dip_q;
    status_d      = status_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    log_we_d      = 1'b0;

    if (bridge_rd) rd_data_d = w_rd_val;

    if (bridge_wr && w_hit) begin
      case (w_ofs)
        OFS_PARAM0: param0_d       = bridge_wr_data;
        OFS_PARAM1: param1_d       = bridge_wr_data;
        OFS_DIP_LO: dip_d[31:0]    = bridge_wr_data;
        OFS_DIP_HI: dip_d[63:32]   = bridge_wr_data;
        default: ;
      endcase
    end

    if (w_cmd_wr && !w_tag_ok) err_d = 1'b1;
    if (w_cmd_wr && w_tag_ok && w_busy) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        if (w_cmd_wr && w_tag_ok) begin
          opcode_d = w_op;
          done_d   = 1'b0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode_q)
          OP_NOP:         state_d = ST_DONE;
          OP_RESET_ENTER: begin rst_req_d = 1'b1; state_d = ST_RST_HOLD; end
          OP_RESET_EXIT:  begin rst_req_d = 1'b0; state_d = ST_DONE; end
          OP_SLOT_LOAD: begin
            slot_id_d     = param0_q[15:0];
            slot_size_d   = param1_q;
            downloading_d = 1'b1;
            load_start_d  = 1'b1;
            cnt_d         = 24'd0;
            state_d       = ST_LOAD;
          end
          OP_DIP_COMMIT: begin status_d = dip_q; state_d = ST_DONE; end
          default:        state_d = ST_ERR;
        endcase
      end
      ST_RST_HOLD: begin
        if (w_cmd_wr && w_tag_ok) begin
          opcode_d = w_op;
          done_d   = 1'b0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          if (w_op == OP_RESET_EXIT) begin
            rst_req_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_ERR;
          end
        end
      end
      ST_LOAD: begin
        cnt_d = cnt_q + 24'd1;
        if (dwnld_busy) begin
          state_d = ST_LOAD_WAIT;
        end else if (w_timeout) begin
          downloading_d = 1'b0;
          state_d       = ST_ERR;
        end
      end
      ST_LOAD_WAIT: begin
        cnt_d = cnt_q + 24'd1;
        if (!dwnld_busy) begin
          downloading_d = 1'b0;
          state_d       = ST_DONE;
        end else if (w_timeout) begin
          downloading_d = 1'b0;
          state_d       = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Result flags are raised on entry so they are visible while in the result state.
    if (state_d != state_q &&
        (state_d == ST_DONE || state_d == ST_ERR || state_d == ST_RST_HOLD)) begin
      done_d   = 1'b1;
      log_we_d = 1'b1;
      if (state_d == ST_ERR) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      rst_req_q     <= 1'b0;
      downloading_q <= 1'b0;
      load_start_q  <= 1'b0;
      slot_id_q     <= '0;
      slot_size_q   <= '0;
      param0_q      <= '0;
      param1_q      <= '0;
      dip_q         <= DIP_DEFAULT;
      status_q      <= DIP_DEFAULT;
      cnt_q         <= '0;
      rd_data_q     <= '0;
      log_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      done_q        <= done_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
      rst_req_q     <= rst_req_d;
      downloading_q <= downloading_d;
      load_start_q  <= load_start_d;
      slot_id_q     <= slot_id_d;
      slot_size_q   <= slot_size_d;
      param0_q      <= param0_d;
      param1_q      <= param1_d;
      dip_q         <= dip_d;
      status_q      <= status_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      log_we_q      <= log_we_d;
    end
  end

  assign bridge_rd_data = rd_data_q;
  assign status         = status_q;
  assign rst_req        = rst_req_q;
  assign downloading    = downloading_q;
  assign load_start     = load_start_q;
  assign slot_id        = slot_id_q;
  assign slot_size      = slot_size_q;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_pocket_cmd.sv
// +---------------------------------------------------------------------------+
// | tb_jtframe_pocket_cmd: directed self-checking bench for the command block.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_jtframe_pocket_cmd;

  localparam logic [63:0] C_DIP_DEF = 64'h0123_4567_89AB_CDEF;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [31:0] bridge_addr, bridge_wr_data, bridge_rd_data;
  logic        bridge_rd, bridge_wr, dwnld_busy;
  logic [63:0] status;
  logic        rst_req, downloading, load_start;
  logic [15:0] slot_id;
  logic [31:0] slot_size;

  int n_cmp  = 0;
  int n_fail = 0;

  jtframe_pocket_cmd #(.TIMEOUT(24'd100), .DIP_DEFAULT(C_DIP_DEF)) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .bridge_addr    (bridge_addr),
    .bridge_rd      (bridge_rd),
    .bridge_wr      (bridge_wr),
    .bridge_wr_data (bridge_wr_data),
    .bridge_rd_data (bridge_rd_data),
    .dwnld_busy     (dwnld_busy),
    .status         (status),
    .rst_req        (rst_req),
    .downloading    (downloading),
    .load_start     (load_start),
    .slot_id        (slot_id),
    .slot_size      (slot_size)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
    tick(1);
    bridge_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bridge_addr = a; bridge_rd = 1'b1;
    tick(1);
    bridge_rd = 1'b0;
    d = bridge_rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1; tick(3); rst = 1'b0;
    n_cmp++; if (status !== C_DIP_DEF) begin n_fail++; $display("FAIL reset_status got %h want %h", status, C_DIP_DEF); end
    n_cmp++; if ({rst_req, downloading, load_start} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {rst_req, downloading, load_start}); end
    n_cmp++; if ({slot_id, slot_size} !== 48'd0) begin n_fail++; $display("FAIL reset_slot got %h want 0", {slot_id, slot_size}); end
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_stat got %h want 0", r); end
  endtask

  task automatic test_dip_commit;
    logic [31:0] r;
    bus_write(32'hF800_0100, 32'h0000_00A5);
    bus_write(32'hF800_0104, 32'h0000_0001);
    tick(2);
    n_cmp++; if (status !== C_DIP_DEF) begin n_fail++; $display("FAIL dip_shadow_only got %h want %h", status, C_DIP_DEF); end
    bus_read(32'hF800_0100, r);
    n_cmp++; if (r !== 32'h0000_00A5) begin n_fail++; $display("FAIL dip_lo_read got %h want 000000a5", r); end
    bus_write(32'hF800_0000, 32'h434D_0090);
    tick(2);
    n_cmp++; if (status !== 64'h1_0000_00A5) begin n_fail++; $display("FAIL dip_commit got %h want 00000001000000a5", status); end
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h4000_0090) begin n_fail++; $display("FAIL dip_stat got %h want 40000090", r); end
  endtask

  task automatic test_reset_cmd;
    logic [31:0] r;
    bus_write(32'hF800_0000, 32'h434D_0010);
    tick(1);
    n_cmp++; if (rst_req !== 1'b1) begin n_fail++; $display("FAIL rst_enter got %b want 1", rst_req); end
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h4000_0010) begin n_fail++; $display("FAIL rst_hold_stat got %h want 40000010", r); end
    bus_write(32'hF800_0000, 32'h434D_0011);
    n_cmp++; if (rst_req !== 1'b0) begin n_fail++; $display("FAIL rst_exit got %b want 0", rst_req); end
    tick(1);
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h4000_0011) begin n_fail++; $display("FAIL rst_exit_stat got %h want 40000011", r); end
  endtask

  task automatic test_bus_access;
    logic [31:0] r;
    bus_write(32'hF800_0004, 32'h0000_1111);
    bridge_addr = 32'hF800_0004; bridge_wr_data = 32'h0000_2222;
    bridge_wr = 1'b1; bridge_rd = 1'b1;
    tick(1);
    bridge_wr = 1'b0; bridge_rd = 1'b0;
    n_cmp++; if (bridge_rd_data !== 32'h0000_1111) begin n_fail++; $display("FAIL rd_wr_old got %h want 00001111", bridge_rd_data); end
    bus_write(32'h0000_0004, 32'hFFFF_FFFF);
    bus_read(32'hF800_0004, r);
    n_cmp++; if (r !== 32'h0000_2222) begin n_fail++; $display("FAIL param0_new got %h want 00002222", r); end
    bus_read(32'h0800_0004, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL out_of_window got %h want 0", r); end
    bus_read(32'hF800_0200, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h want 0", r); end
`ifndef JTFRAME_POCKET_CMDLOG_EN
    bus_read(32'hF800_0020, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL log_absent got %h want 0", r); end
`endif
  endtask

  task automatic test_slot_load;
    logic [31:0] r;
    bus_write(32'hF800_0004, 32'h0000_0003);
    bus_write(32'hF800_0008, 32'h0002_0000);
    bus_write(32'hF800_0000, 32'h434D_0080);
    tick(1);
    n_cmp++; if (load_start !== 1'b1) begin n_fail++; $display("FAIL load_start_hi got %b want 1", load_start); end
    n_cmp++; if ({slot_id, slot_size, downloading} !== {16'd3, 32'h0002_0000, 1'b1}) begin
      n_fail++; $display("FAIL slot_latch got %h/%h/%b want 0003/00020000/1", slot_id, slot_size, downloading); end
    tick(1);
    n_cmp++; if (load_start !== 1'b0) begin n_fail++; $display("FAIL load_start_pulse got %b want 0", load_start); end
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h8000_0080) begin n_fail++; $display("FAIL load_busy_stat got %h want 80000080", r); end
    bus_write(32'hF800_0000, 32'h434D_0010);
    dwnld_busy = 1'b1;
    tick(50);
    n_cmp++; if (downloading !== 1'b1) begin n_fail++; $display("FAIL load_wait_dl got %b want 1", downloading); end
    dwnld_busy = 1'b0;
    for (int i = 0; i < 10 && downloading; i++) tick(1);
    n_cmp++; if (downloading !== 1'b0) begin n_fail++; $display("FAIL load_end_dl got %b want 0", downloading); end
    n_cmp++; if (rst_req !== 1'b0) begin n_fail++; $display("FAIL ovf_ignored got %b want 0", rst_req); end
    tick(1);
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h5000_0080) begin n_fail++; $display("FAIL load_done_stat got %h want 50000080", r); end
  endtask

  task automatic test_timeout;
    logic [31:0] r;
    bus_write(32'hF800_0000, 32'h434D_0080);
    tick(1);
    n_cmp++; if (load_start !== 1'b1) begin n_fail++; $display("FAIL to_load_start got %b want 1", load_start); end
    tick(99);
    n_cmp++; if (downloading !== 1'b1) begin n_fail++; $display("FAIL to_before got %b want 1", downloading); end
    tick(1);
    n_cmp++; if (downloading !== 1'b0) begin n_fail++; $display("FAIL to_at_100 got %b want 0", downloading); end
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h6000_0080) begin n_fail++; $display("FAIL to_stat got %h want 60000080", r); end
  endtask

  task automatic test_bad_cmd;
    logic [31:0] r;
    bus_write(32'hF800_0000, 32'h434D_0000);
    tick(2);
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL nop_stat got %h want 40000000", r); end
    bus_write(32'hF800_0000, 32'h1234_0000);
    tick(2);
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h6000_0000) begin n_fail++; $display("FAIL bad_tag_stat got %h want 60000000", r); end
    bus_write(32'hF800_0000, 32'h434D_0055);
    tick(2);
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h6000_0055) begin n_fail++; $display("FAIL bad_op_stat got %h want 60000055", r); end
    bus_write(32'hF800_0000, 32'h434D_0000);
    tick(2);
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL recover_stat got %h want 40000000", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    bus_write(32'hF800_0000, 32'h434D_0080);
    tick(2);
    dwnld_busy = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    n_cmp++; if ({downloading, rst_req, load_start} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ctrl got %b want 000", {downloading, rst_req, load_start}); end
    n_cmp++; if (status !== C_DIP_DEF) begin n_fail++; $display("FAIL mid_rst_status got %h want %h", status, C_DIP_DEF); end
    rst = 1'b0; dwnld_busy = 1'b0;
    bus_read(32'hF800_0010, r);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mid_rst_stat got %h want 0", r); end
    bus_read(32'hF800_0100, r);
    n_cmp++; if (r !== C_DIP_DEF[31:0]) begin n_fail++; $display("FAIL mid_rst_dip got %h want %h", r, C_DIP_DEF[31:0]); end
  endtask

  initial begin
    rst = 1'b1; bridge_addr = '0; bridge_wr_data = '0;
    bridge_rd = 1'b0; bridge_wr = 1'b0; dwnld_busy = 1'b0;
    test_reset;
    test_dip_commit;
    test_reset_cmd;
    test_bus_access;
    test_slot_load;
    test_timeout;
    test_bad_cmd;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
